aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer that time-multiplexes a single external round datapath across all ten rounds. It sits between the block-level valid/ready stream and the combinational round logic: SubBytes, ShiftRows, MixColumns and AddRoundKey, plus one-step key expansion. The block owns the state and round-key registers, the round counter and the Rcon schedule, and it performs the initial AddRoundKey itself.

---
 rtl/aes_round_ctrl_if.sv | 33 +++
 rtl/aes_round_ctrl.sv | 121 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Block-level stream interface of the AES-128 round sequencer: a
// plaintext/key input handshake and a ciphertext output handshake.
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;

    // Environment side: offers plaintext/key pairs and consumes ciphertext.
    modport master (
        output in_valid,
        output din,
        output key,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dout
    );

    // Sequencer side.
    modport slave (
        input  in_valid,
        input  din,
        input  key,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dout
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer. Holds the state and round-key
// registers, runs the round counter and Rcon schedule, performs the initial
// AddRoundKey on accept, and feeds one external combinational round/key
// expansion datapath for ten consecutive cycles per block.
module aes_round_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    aes_round_ctrl_if.slave        bus,
    output logic [127:0]           rnd_state_out,
    output logic [127:0]           rnd_key_out,
    output logic [7:0]             rnd_rcon,
    output logic                   rnd_last,
    input  logic [127:0]           rnd_state_in,
    input  logic [127:0]           rnd_key_in
);

    localparam logic [3:0] LAST_RC = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       fsm;
    logic [3:0]   rc;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic         out_valid_reg;
    logic         last_reg;
    logic [7:0]   rcon_reg;
    logic         ready;
    logic         accept;

    // Rcon byte used by the key-expansion step of round n (1..10).
    function automatic logic [7:0] rcon_for(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // in_ready looks at out_ready directly so a finishing block can hand
    // over to the next one in the same cycle (one block per 11 cycles).
    assign ready  = (fsm == IDLE) || ((fsm == DONE) && bus.out_ready);
    assign accept = bus.in_valid && ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_reg;
    // dout is forced to zero outside DONE so nothing stale leaks after reset.
    assign bus.dout      = out_valid_reg ? state_reg : '0;

    assign rnd_state_out = state_reg;
    assign rnd_key_out   = key_reg;
    assign rnd_rcon      = rcon_reg;
    assign rnd_last      = last_reg;

    // Sequencer: accept/initial AddRoundKey, ten datapath rounds, output hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= IDLE;
            rc            <= 4'd0;
            state_reg     <= '0;
            key_reg       <= '0;
            out_valid_reg <= 1'b0;
            rcon_reg      <= 8'h00;
            last_reg      <= 1'b0;
        end else if (accept) begin
            // Only reachable from IDLE or from DONE with the output taken.
            fsm           <= ROUND;
            rc            <= 4'd1;
            state_reg     <= bus.din ^ bus.key;
            key_reg       <= bus.key;
            out_valid_reg <= 1'b0;
            rcon_reg      <= rcon_for(4'd1);
            last_reg      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    rc <= 4'd0;
                end
                ROUND: begin
                    state_reg <= rnd_state_in;
                    key_reg   <= rnd_key_in;
                    if (rc == LAST_RC) begin
                        fsm           <= DONE;
                        rc            <= 4'd0;
                        out_valid_reg <= 1'b1;
                        rcon_reg      <= 8'h00;
                        last_reg      <= 1'b0;
                    end else begin
                        rc       <= rc + 4'd1;
                        rcon_reg <= rcon_for(rc + 4'd1);
                        last_reg <= (rc == LAST_RC - 4'd1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm           <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: models the AES-128 round datapath, checks
// FIPS-197 vectors, backpressure, back-to-back, mid-round reset and busy
// input rejection, then runs randomized traffic against a scoreboard.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus_if ();

    logic [127:0] rnd_state_out;
    logic [127:0] rnd_key_out;
    logic [7:0]   rnd_rcon;
    logic         rnd_last;
    logic [127:0] rnd_state_in;
    logic [127:0] rnd_key_in;

    aes_round_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .rnd_state_out (rnd_state_out),
        .rnd_key_out   (rnd_key_out),
        .rnd_rcon      (rnd_rcon),
        .rnd_last      (rnd_last),
        .rnd_state_in  (rnd_state_in),
        .rnd_key_in    (rnd_key_in)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (a^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv, s, b;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        s = inv;
        b = inv;
        for (int i = 0; i < 4; i++) begin
            b = {b[6:0], b[7]};
            s = s ^ b;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] t [16];
        logic [7:0] m0, m1, m2, m3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                t[w + 4*c] = a[w + 4*((c + w) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                m0 = t[4*c]; m1 = t[4*c+1]; m2 = t[4*c+2]; m3 = t[4*c+3];
                t[4*c]   = xt(m0) ^ xt(m1) ^ m1 ^ m2 ^ m3;
                t[4*c+1] = m0 ^ xt(m1) ^ xt(m2) ^ m2 ^ m3;
                t[4*c+2] = m0 ^ m1 ^ xt(m2) ^ xt(m3) ^ m3;
                t[4*c+3] = xt(m0) ^ m0 ^ m1 ^ m2 ^ xt(m3);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i] ^ k[127-8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Rcon for round n as repeated doubling in GF(2^8).
    function automatic logic [7:0] model_rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < n; i++) r = xt(r);
        return r;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s, rk;
        s  = pt ^ k;
        rk = k;
        for (int r = 1; r <= 10; r++) begin
            rk = expand(rk, model_rcon(r));
            s  = aes_round(s, rk, r == 10);
        end
        return s;
    endfunction

    function automatic logic [7:0] fips_rcon(input int n);
        logic [7:0] r;
        case (n)
            1: r = 8'h01; 2: r = 8'h02; 3: r = 8'h04; 4: r = 8'h08; 5: r = 8'h10;
            6: r = 8'h20; 7: r = 8'h40; 8: r = 8'h80; 9: r = 8'h1b; 10: r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Combinational round datapath and key expansion seen by the sequencer.
    assign rnd_key_in   = expand(rnd_key_out, rnd_rcon);
    assign rnd_state_in = aes_round(rnd_state_out, rnd_key_in, rnd_last);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Scoreboard ----------------
    typedef struct {
        int           acc;
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] ct;
    } job_t;

    job_t q[$];
    bit   armed = 1'b0;

    always @(negedge clk) begin : monitor
        bit         busy, exp_ov, exp_ir, exp_last;
        int         age;
        logic [7:0] exp_rcon;
        job_t       j;
        busy     = (q.size() > 0);
        age      = busy ? (cyc - q[0].acc) : 0;
        exp_ov   = busy && (age >= 11);
        exp_ir   = !busy || (exp_ov && bus_if.out_ready);
        exp_last = busy && (age == 10);
        exp_rcon = (busy && age >= 1 && age <= 10) ? model_rcon(age) : 8'h00;
        if (armed) begin
            check("mon in_ready", 128'(bus_if.in_ready), 128'(exp_ir));
            check("mon out_valid", 128'(bus_if.out_valid), 128'(exp_ov));
            check("mon rnd_rcon", 128'(rnd_rcon), 128'(exp_rcon));
            check("mon rnd_last", 128'(rnd_last), 128'(exp_last));
            if (exp_ov) check("mon dout", bus_if.dout, q[0].ct);
            if (busy && age == 1) begin
                check("mon initial addroundkey", rnd_state_out, q[0].pt ^ q[0].k);
                check("mon round key load", rnd_key_out, q[0].k);
            end
        end
        if (rst) begin
            q.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (exp_ov && bus_if.out_ready) void'(q.pop_front());
            if (bus_if.in_valid && exp_ir) begin
                j.acc = cyc;
                j.pt  = bus_if.din;
                j.k   = bus_if.key;
                j.ct  = aes_encrypt(bus_if.din, bus_if.key);
                q.push_back(j);
            end
        end
    end

    // ---------------- Directed sequences ----------------
    typedef struct {
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] ct;
    } vec_t;

    vec_t vt [3];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Waits for out_valid (bounded), checking the round schedule on the way.
    task automatic wait_out(input string tag, inout int lat);
        while (!bus_if.out_valid && lat < 30) begin
            if (lat >= 1 && lat <= 10) begin
                check({tag, " rnd_rcon"}, 128'(rnd_rcon), 128'(fips_rcon(lat)));
                check({tag, " rnd_last"}, 128'(rnd_last), 128'(lat == 10));
            end
            tick();
            lat++;
        end
    endtask

    task automatic run_one(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct, input string tag);
        int lat;
        bus_if.din       = pt;
        bus_if.key       = k;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 128'(bus_if.in_ready), 128'd1);
        tick();
        bus_if.in_valid = 1'b0;
        lat = 1;
        wait_out(tag, lat);
        check({tag, " latency"}, 128'(lat), 128'd11);
        check({tag, " dout"}, bus_if.dout, ct);
        tick();
        check({tag, " out_valid after handshake"}, 128'(bus_if.out_valid), 128'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int acc_c [3];
        int ai, hs, bsel;
        bit adv;

        vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32};
        vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.din       = '0;
        bus_if.key       = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check("reset in_ready", 128'(bus_if.in_ready), 128'd1);
        check("reset out_valid", 128'(bus_if.out_valid), 128'd0);
        check("reset dout", bus_if.dout, 128'd0);
        check("reset rnd_rcon", 128'(rnd_rcon), 128'd0);
        check("reset rnd_last", 128'(rnd_last), 128'd0);
        check("reset state", rnd_state_out, 128'd0);
        check("reset key", rnd_key_out, 128'd0);

        // Known-answer table
        for (int i = 0; i < 3; i++) run_one(vt[i].pt, vt[i].k, vt[i].ct, $sformatf("kat%0d", i));

        // Output backpressure for 20 cycles with in_valid pulses
        bus_if.out_ready = 1'b0;
        bus_if.din = vt[0].pt; bus_if.key = vt[0].k; bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        lat = 1;
        wait_out("bp", lat);
        check("bp latency", 128'(lat), 128'd11);
        for (int i = 0; i < 20; i++) begin
            bus_if.in_valid = i[0];
            bus_if.din = {$urandom, $urandom, $urandom, $urandom};
            bus_if.key = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("bp dout", bus_if.dout, vt[0].ct);
            check("bp in_ready", 128'(bus_if.in_ready), 128'd0);
            check("bp out_valid", 128'(bus_if.out_valid), 128'd1);
            tick();
        end
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        check("bp release out_valid", 128'(bus_if.out_valid), 128'd0);
        check("bp release in_ready", 128'(bus_if.in_ready), 128'd1);
        tick();
        check("bp single handshake", 128'(bus_if.out_valid), 128'd0);

        // Back-to-back: C.1, B, C.1 with in_valid and out_ready held high
        acc_c[0] = -100; acc_c[1] = -50; acc_c[2] = 0;
        ai = 0; hs = 0; bsel = 0;
        bus_if.out_ready = 1'b1;
        bus_if.din = vt[0].pt; bus_if.key = vt[0].k; bus_if.in_valid = 1'b1;
        for (int c = 0; c < 60 && hs < 3; c++) begin
            #1;
            adv = 1'b0;
            if (bus_if.out_valid && bus_if.out_ready) begin
                check($sformatf("b2b dout%0d", hs), bus_if.dout, vt[(hs == 1) ? 1 : 0].ct);
                hs++;
            end
            if (bus_if.in_valid && bus_if.in_ready && ai < 3) begin
                acc_c[ai] = cyc;
                if (ai > 0) check("b2b accept on handshake", 128'(bus_if.out_valid), 128'd1);
                ai++;
                adv = 1'b1;
            end
            tick();
            if (adv) begin
                if (ai < 3) begin
                    bsel = (ai == 1) ? 1 : 0;
                    bus_if.din = vt[bsel].pt; bus_if.key = vt[bsel].k;
                end else begin
                    bus_if.in_valid = 1'b0;
                end
            end
        end
        bus_if.in_valid = 1'b0;
        check("b2b handshakes", 128'(hs), 128'd3);
        check("b2b accepts", 128'(ai), 128'd3);
        check("b2b spacing 1", 128'(acc_c[1] - acc_c[0]), 128'd11);
        check("b2b spacing 2", 128'(acc_c[2] - acc_c[1]), 128'd11);
        tick();

        // Reset in round 5
        bus_if.din = vt[0].pt; bus_if.key = vt[0].k; bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("mid rst round5 rcon", 128'(rnd_rcon), 128'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst in_ready", 128'(bus_if.in_ready), 128'd1);
        check("mid rst out_valid", 128'(bus_if.out_valid), 128'd0);
        check("mid rst dout", bus_if.dout, 128'd0);
        check("mid rst rnd_rcon", 128'(rnd_rcon), 128'd0);
        check("mid rst rnd_last", 128'(rnd_last), 128'd0);
        run_one(vt[0].pt, vt[0].k, vt[0].ct, "after rst");

        // in_valid with other data during rounds is ignored
        bus_if.din = vt[0].pt; bus_if.key = vt[0].k; bus_if.in_valid = 1'b1;
        tick();
        lat = 1;
        for (int i = 0; i < 9; i++) begin
            bus_if.din = vt[1].pt; bus_if.key = vt[1].k; bus_if.in_valid = 1'b1;
            tick();
            lat++;
        end
        bus_if.in_valid = 1'b0;
        wait_out("busy", lat);
        check("busy latency", 128'(lat), 128'd11);
        check("busy dout", bus_if.dout, vt[0].ct);
        tick();
        for (int i = 0; i < 15; i++) begin
            check("busy no second output", 128'(bus_if.out_valid), 128'd0);
            tick();
        end

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            bus_if.in_valid  = ($urandom_range(0, 2) != 0);
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            bus_if.din = {$urandom, $urandom, $urandom, $urandom};
            bus_if.key = {$urandom, $urandom, $urandom, $urandom};
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (15) tick();
        check("drain scoreboard empty", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
